// File: rtl/mem_stream_reader_pkg.sv
// Shared types and helpers for the mem_stream_reader block: FSM state encoding
// and the DEPTH-aware address incrementer.
package mem_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Wraps at depth-1 rather than at the natural width, so non-power-of-two RAMs work.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/mem_stream_out_reg.sv
// One-entry output stage for mem_stream_reader: holds the beat presented on the
// valid/ready stream. Load takes priority over clear.
module mem_stream_out_reg #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_last,
    output logic [DWIDTH-1:0] data,
    output logic              last,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            last  <= load_last;
            valid <= 1'b1;
        end else if (clear) begin
            last  <= 1'b0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Streams len words from an async-read RAM starting at base_addr onto a valid/ready port.
// Optional running checksum of delivered beats: define MEM_STREAM_READER_CHECKSUM_EN.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int          DWIDTH = 8,
    parameter int          AWIDTH = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_q,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DWIDTH-1:0] checksum
`endif
);

    localparam int CW = AWIDTH + 1;

    state_t          state;
    state_t          state_next;
    logic [AWIDTH:0] remaining;
    logic            accept;
    logic            load;
    logic            clear;
    logic            load_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start coinciding with the done pulse is dropped, enforcing one idle cycle between transfers.
    always_comb begin
        state_next = state;
        accept     = (state == IDLE) && start && !done;
        load       = 1'b0;
        clear      = 1'b0;
        load_last  = (remaining == CW'(1));
        case (state)
            IDLE: begin
                if (accept && (len != '0)) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                load = !out_valid || out_ready;
                if (load && load_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                clear = out_ready;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (accept && (len == '0)) || clear;
            if (accept) begin
                remaining <= len;
            end else if (load) begin
                remaining <= remaining - CW'(1);
            end
            if (accept && (len != '0)) begin
                mem_addr <= base_addr;
                busy     <= 1'b1;
            end else begin
                if (load) begin
                    mem_addr <= AWIDTH'(next_addr(32'(mem_addr), DEPTH));
                end
                if (clear) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    mem_stream_out_reg #(
        .DWIDTH(DWIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .clear    (clear),
        .load_data(mem_q),
        .load_last(load_last),
        .data     (out_data),
        .last     (out_last),
        .valid    (out_valid)
    );

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (out_valid && out_ready) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader on a 10-deep RAM: vector table, hand-written
// corner sequences and randomized transfers checked against a queue-based beat model.
module tb_mem_stream_reader;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int DEP = 10;
    localparam int LW  = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [DEP];

    assign mem_q = (int'(mem_addr) < DEP) ? mem[int'(mem_addr)] : 8'hEE;

    always #5 clk = ~clk;

    mem_stream_reader #(
        .DWIDTH(DW),
        .AWIDTH(AW),
        .DEPTH (DEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_q    (mem_q),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    int            vectors     = 0;
    int            miscompares = 0;
    int            addr_errs   = 0;
    int            beats_seen  = 0;
    logic [DW-1:0] first_data;
    logic [DW-1:0] final_data;
    logic [DW-1:0] exp_data_q[$];
    logic          exp_last_q[$];

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_edges;
        int exp_first;
        int exp_final;
    } vec_t;

    vec_t table_v[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
        vectors++;
        if (actual !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input int b, input int l, input logic r);
        start     = s;
        base_addr = AW'(b);
        len       = LW'(l);
        out_ready = r;
    endtask

    // mode 0: always ready, mode 1: 1,0,0,1 repeating, mode 2: random
    function automatic logic readyFor(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((k % 4) == 0) || ((k % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Beat scoreboard plus backpressure stability, sampled mid-cycle.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin
        logic [DW-1:0] d;
        logic          l;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (int'(mem_addr) >= DEP) addr_errs++;
            if (prev_stall) begin
                checkOutput("stall_data", 32'(out_data), 32'(prev_data));
                checkOutput("stall_last", 32'(out_last), 32'(prev_last));
                checkOutput("stall_addr", 32'(mem_addr), 32'(prev_addr));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_addr  = mem_addr;
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    checkOutput("extra_beat", 32'd1, 32'd0);
                end else begin
                    d = exp_data_q.pop_front();
                    l = exp_last_q.pop_front();
                    checkOutput("beat_data", 32'(out_data), 32'(d));
                    checkOutput("beat_last", 32'(out_last), 32'(l));
                    if (beats_seen == 0) first_data = out_data;
                    if (out_last) final_data = out_data;
                    beats_seen++;
                end
            end
        end
    end

    task automatic runTransfer(input int b, input int l, input int mode, input int exp_edges,
                               input bit poke_busy, input bit poke_done);
        int sum;
        int edges;
        bit got;
        sum        = 0;
        beats_seen = 0;
        first_data = '0;
        final_data = '0;
        @(posedge clk); #1;
        for (int i = 0; i < l; i++) begin
            exp_data_q.push_back(mem[(b + i) % DEP]);
            exp_last_q.push_back(i == l - 1);
            sum += int'(mem[(b + i) % DEP]);
        end
        applyStimulus(1'b1, b, l, readyFor(mode, 0));
        @(posedge clk); #1;
        checkOutput("busy_on_accept", 32'(busy), 32'(l != 0));
        if (l != 0) checkOutput("addr_latched", 32'(mem_addr), 32'(b));
        if (l == 0) checkOutput("no_valid_len0", 32'(out_valid), 32'd0);
        edges = 0;
        got   = done;
        while (!got && edges < 200) begin
            if (poke_busy && edges == 1)
                applyStimulus(1'b1, (b + 3) % DEP, 5, readyFor(mode, edges));
            else
                applyStimulus(1'b0, b, l, readyFor(mode, edges));
            @(posedge clk); #1;
            edges++;
            if (edges == 1) checkOutput("first_valid", 32'(out_valid), 32'(l != 0));
            got = done;
        end
        checkOutput("done_seen", 32'(got), 32'd1);
        if (exp_edges >= 0) checkOutput("done_latency", 32'(edges), 32'(exp_edges));
        checkOutput("busy_with_done", 32'(busy), 32'd0);
        checkOutput("beat_count", 32'(beats_seen), 32'(l));
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        checkOutput("checksum", 32'(checksum), 32'(sum & 32'hFF));
`endif
        if (poke_done) applyStimulus(1'b1, 0, 2, 1'b1);
        else           applyStimulus(1'b0, b, l, 1'b1);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        applyStimulus(1'b0, b, l, 1'b1);
        if (poke_done) begin
            checkOutput("start_on_done_busy", 32'(busy), 32'd0);
            repeat (4) @(posedge clk);
            #1;
            checkOutput("start_on_done_beats", 32'(beats_seen), 32'(l));
        end
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        int b;
        int l;
        int m;
        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < DEP; i++) mem[i] = DW'(i);

        table_v[0] = '{4, 3, 0, 4, 4, 6};
        table_v[1] = '{8, 4, 0, 5, 8, 1};
        table_v[2] = '{8, 4, 1, -1, 8, 1};
        table_v[3] = '{0, 1, 0, 2, 0, 0};
        table_v[4] = '{9, 10, 0, 11, 9, 8};
        table_v[5] = '{3, 0, 0, 0, 0, 0};
        table_v[6] = '{2, 5, 2, -1, 2, 6};

        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        checkOutput("rst_checksum", 32'(checksum), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            runTransfer(table_v[i].base, table_v[i].len, table_v[i].mode, table_v[i].exp_edges, 1'b0, 1'b0);
            if (table_v[i].len != 0) begin
                checkOutput("first_beat", 32'(first_data), 32'(table_v[i].exp_first));
                checkOutput("final_beat", 32'(final_data), 32'(table_v[i].exp_final));
            end
        end

        // start while busy, and start during the done cycle, must both be ignored
        runTransfer(4, 3, 0, 4, 1'b1, 1'b1);
        runTransfer(6, 2, 1, -1, 1'b1, 1'b1);

        // reset mid-transfer clears outputs without waiting for an edge
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            exp_data_q.push_back(mem[(2 + i) % DEP]);
            exp_last_q.push_back(i == 5);
        end
        applyStimulus(1'b1, 2, 6, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 2, 6, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        exp_data_q.delete();
        exp_last_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        checkOutput("post_rst_done", 32'(done), 32'd0);
        runTransfer(5, 2, 0, 3, 1'b0, 1'b0);
        checkOutput("post_rst_final", 32'(final_data), 32'd6);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < DEP; i++) mem[i] = DW'($urandom);
            b = int'($urandom_range(0, DEP - 1));
            l = int'($urandom_range(0, DEP));
            m = int'($urandom_range(0, 2));
            runTransfer(b, l, m, (m == 0) ? ((l == 0) ? 0 : l + 1) : -1, 1'b0, 1'b0);
        end

        mem[0] = 8'hF0;
        mem[1] = 8'h20;
        runTransfer(0, 2, 0, 3, 1'b0, 1'b0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        checkOutput("checksum_f0_20", 32'(checksum), 32'h10);
`endif

        checkOutput("addr_in_range", 32'(addr_errs), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
